// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter granting NUM_REQ requesters access to one
// transmitter; sends one payload per grant and waits for ack or timeout.
// Ports:
//   clk, rst          - clock, async active-high reset
//   req_valid/data    - per-requester request and payload (packed)
//   req_done/err      - one-cycle completion / timeout pulse to the winner
//   tx_data/tx_valid  - payload and start strobe to the transmitter
//   tx_ack_synced     - transmitter completion pulse (clk domain)
//   grant_id, busy    - requester being served, non-idle indicator
module tx_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [NUM_REQ-1:0]             req_err,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ack_synced,
  output logic [((NUM_REQ<2)?1:$clog2(NUM_REQ))-1:0] grant_id,
  output logic                           busy
);

  localparam int GW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam logic [15:0] TMAX = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT, DONE
  } state_t;

  state_t state, state_n;

  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        winner;
  logic [DATA_BITS-1:0] win_data;
  logic                 found;
  logic [15:0]          cnt;
  int                   idx;

  // Search starts just after the last grant and wraps, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    winner   = '0;
    win_data = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        winner   = GW'(idx);
        win_data = req_data[idx*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Ack is checked before the timeout so a simultaneous ack wins.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (found) state_n = SEND;
      SEND: state_n = WAIT;
      WAIT: if (tx_ack_synced || cnt == TMAX) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id   <= '0;
      tx_data    <= '0;
      cnt        <= '0;
      req_done   <= '0;
      req_err    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            tx_data  <= win_data;
          end
        end
        SEND: cnt <= '0;
        WAIT: begin
          if (tx_ack_synced)
            req_done <= NUM_REQ'(1) << grant_id;
          else if (cnt == TMAX)
            req_err <= NUM_REQ'(1) << grant_id;
          if (cnt != TMAX) cnt <= cnt + 16'd1;
        end
        DONE: last_grant <= grant_id;
        default: ;
      endcase
    end
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: table-driven bench for tx_arbiter with a queue scoreboard
// and hand-written sequences for stray acks and mid-transfer reset.
module tb_tx_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_done;
  logic [NR-1:0]   req_err;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ack;
  logic [1:0]      grant_id;
  logic            busy;

  tx_arbiter #(.DATA_BITS(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_done      (req_done),
    .req_err       (req_err),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ack_synced (tx_ack),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    int         dly;
    int         grant;
    bit         err;
  } vec_t;

  typedef struct {
    int          grant;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  logic [31:0] pay[4];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int g);
    return 64'(1) << g;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    int   want;
    bit   seen;
    e.grant = v.grant;
    e.data  = pay[v.grant];
    e.err   = v.err;
    sb.push_back(e);
    req_valid = v.rv;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tx_valid_seen", 64'(seen), 64'(1));
    if (!seen) begin
      e = sb.pop_front();
      return;
    end
    chk("grant_id", 64'(grant_id), 64'(sb[0].grant));
    chk("tx_data", 64'(tx_data), 64'(sb[0].data));
    lat = 0;
    if (v.dly >= 1 && v.dly <= TO + 1) begin
      repeat (v.dly) begin
        @(negedge clk);
        lat++;
        if (lat == 1) chk("tx_valid_1cyc", 64'(tx_valid), 64'(0));
      end
      tx_ack = 1'b1;
      @(negedge clk);
      lat++;
      tx_ack = 1'b0;
      want = v.dly + 1;
    end else begin
      want = TO + 2;
    end
    while (req_done == 0 && req_err == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", 64'(lat), 64'(want));
    chk("req_done", 64'(req_done), e.err ? 64'(0) : oh(e.grant));
    chk("req_err", 64'(req_err), e.err ? oh(e.grant) : 64'(0));
    @(negedge clk);
    chk("pulse_end", 64'({req_done, req_err}), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pay[0] = 32'hA5A5_0001;
    pay[1] = 32'hB6B6_0002;
    pay[2] = 32'hC7C7_0003;
    pay[3] = 32'hD8D8_0004;
    // {req_valid, ack delay after tx_valid (-1 none), grant, timeout}
    vecs[0]  = '{4'b1111,  3, 0, 1'b0};
    vecs[1]  = '{4'b1111,  1, 1, 1'b0};
    vecs[2]  = '{4'b1111,  2, 2, 1'b0};
    vecs[3]  = '{4'b1111,  5, 3, 1'b0};
    vecs[4]  = '{4'b1111,  4, 0, 1'b0};
    vecs[5]  = '{4'b0001,  5, 0, 1'b0};
    vecs[6]  = '{4'b0100, -1, 2, 1'b1};
    vecs[7]  = '{4'b1000,  9, 3, 1'b0};
    vecs[8]  = '{4'b0011,  8, 0, 1'b0};
    vecs[9]  = '{4'b0011,  6, 1, 1'b0};
    vecs[10] = '{4'b0110,  1, 2, 1'b0};
    vecs[11] = '{4'b1001, -1, 3, 1'b1};
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay[i];

    rst = 1'b1;
    req_valid = '0;
    tx_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_resp", 64'({req_done, req_err}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Stray acks in IDLE and SEND are ignored.
    req_valid = '0;
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("stray_idle_busy", 64'(busy), 64'(0));
    chk("stray_idle_done", 64'(req_done), 64'(0));
    req_valid = 4'b0010;
    @(negedge clk);
    chk("stray_send_txv", 64'(tx_valid), 64'(1));
    chk("stray_send_grant", 64'(grant_id), 64'(1));
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("stray_send_busy", 64'(busy), 64'(1));
    chk("stray_send_done", 64'(req_done), 64'(0));
    @(negedge clk);
    chk("stray_send_done2", 64'(req_done), 64'(0));
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("stray_real_done", 64'(req_done), 64'(4'b0010));
    req_valid = '0;
    @(negedge clk);
    chk("stray_back_idle", 64'(busy), 64'(0));

    // Reset during WAIT abandons the transfer; late ack ignored.
    req_valid = 4'b1100;
    @(negedge clk);
    chk("rw_txv", 64'(tx_valid), 64'(1));
    chk("rw_grant", 64'(grant_id), 64'(2));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("rw_busy", 64'(busy), 64'(0));
    chk("rw_grant0", 64'(grant_id), 64'(0));
    chk("rw_data0", 64'(tx_data), 64'(0));
    chk("rw_resp", 64'({req_done, req_err}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_late_ack", 64'({busy, req_done, req_err}), 64'(0));
      @(negedge clk);
    end
    run_vec('{4'b0101, 2, 0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
